// File: rtl/game_pkg.sv
// Shared types for the counter game: FSM states, counter modes and "who ended it" codes.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    CTRL_INC     = 2'b00,
    CTRL_INC_BIG = 2'b01,
    CTRL_DEC     = 2'b10,
    CTRL_DEC_BIG = 2'b11
  } ctrl_mode_t;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

endpackage

// File: rtl/mode_counter.sv
// Wrapping up/down play counter with unit or large step; exposes next value for arrival scoring.
module mode_counter
  import game_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 4,
  parameter int unsigned STEP_BIG     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [COUNTER_SIZE-1:0] load_val,
  input  logic                    en,
  input  logic [1:0]              control,
  output logic [COUNTER_SIZE-1:0] count,
  output logic [COUNTER_SIZE-1:0] nxt
);

  localparam logic [COUNTER_SIZE-1:0] STEP_ONE = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] STEP_LG  = COUNTER_SIZE'(STEP_BIG);

  ctrl_mode_t mode;

  // Modulo-2**N arithmetic wraps naturally in both directions
  always_comb begin
    mode = ctrl_mode_t'(control);
    nxt  = count + STEP_ONE;
    case (mode)
      CTRL_INC:     nxt = count + STEP_ONE;
      CTRL_INC_BIG: nxt = count + STEP_LG;
      CTRL_DEC:     nxt = count - STEP_ONE;
      CTRL_DEC_BIG: nxt = count - STEP_LG;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/game_state_gen2.sv
// Counter-game status: play FSM, saturating win/loss scores and latched game-over.
module game_state_gen2
  import game_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 4,
  parameter int unsigned SCORE_SIZE   = 4,
  parameter int unsigned WIN_LIMIT    = 15,
  parameter int unsigned LOSE_LIMIT   = 15,
  parameter int unsigned STEP_BIG     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [1:0]              control,
  input  logic                    init,
  input  logic [COUNTER_SIZE-1:0] i_value,
  input  logic                    restart,
  output logic [COUNTER_SIZE-1:0] count,
  output logic                    win,
  output logic                    los,
  output logic [SCORE_SIZE-1:0]   wins,
  output logic [SCORE_SIZE-1:0]   losses,
  output logic [1:0]              who,
  output logic                    gameover
);

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX   = '1;
  localparam logic [SCORE_SIZE-1:0]   SCORE_MAX = '1;
  localparam logic [SCORE_SIZE-1:0]   WIN_LIM   = SCORE_SIZE'(WIN_LIMIT);
  localparam logic [SCORE_SIZE-1:0]   LOSE_LIM  = SCORE_SIZE'(LOSE_LIMIT);

  if (WIN_LIMIT < 1 || WIN_LIMIT > (2**SCORE_SIZE) - 1) begin : g_bad_win_limit
    $error("game_state_gen2: WIN_LIMIT out of range");
  end
  if (LOSE_LIMIT < 1 || LOSE_LIMIT > (2**SCORE_SIZE) - 1) begin : g_bad_lose_limit
    $error("game_state_gen2: LOSE_LIMIT out of range");
  end
  if (STEP_BIG < 1 || STEP_BIG > (2**COUNTER_SIZE) - 1) begin : g_bad_step
    $error("game_state_gen2: STEP_BIG out of range");
  end

  game_state_t               state;
  logic                      do_load;
  logic                      do_count;
  logic [COUNTER_SIZE-1:0]   load_val;
  logic [COUNTER_SIZE-1:0]   nxt;
  logic                      arrive_max;
  logic                      arrive_zero;
  logic [SCORE_SIZE-1:0]     wins_inc;
  logic [SCORE_SIZE-1:0]     losses_inc;

  // restart beats init beats counting; OVER ignores init and freezes the counter
  always_comb begin
    do_load     = restart || (init && (state != OVER));
    load_val    = restart ? '0 : i_value;
    do_count    = (state == PLAY) && en && !init && !restart;
    arrive_max  = do_count && (nxt == CNT_MAX) && (nxt != count);
    arrive_zero = do_count && (nxt == '0) && (nxt != count);
    wins_inc    = (wins == SCORE_MAX) ? wins : wins + 1'b1;
    losses_inc  = (losses == SCORE_MAX) ? losses : losses + 1'b1;
  end

  mode_counter #(
    .COUNTER_SIZE(COUNTER_SIZE),
    .STEP_BIG    (STEP_BIG)
  ) u_mode_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (do_load),
    .load_val(load_val),
    .en      (do_count),
    .control (control),
    .count   (count),
    .nxt     (nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wins     <= '0;
      losses   <= '0;
      who      <= WHO_NONE;
      gameover <= 1'b0;
    end else if (restart) begin
      state    <= IDLE;
      wins     <= '0;
      losses   <= '0;
      who      <= WHO_NONE;
      gameover <= 1'b0;
    end else if (init && (state != OVER)) begin
      state  <= PLAY;
      wins   <= '0;
      losses <= '0;
      who    <= WHO_NONE;
    end else if (arrive_max) begin
      wins <= wins_inc;
      if (wins_inc == WIN_LIM) begin
        state    <= OVER;
        who      <= WHO_WINNER;
        gameover <= 1'b1;
      end
    end else if (arrive_zero) begin
      losses <= losses_inc;
      if (losses_inc == LOSE_LIM) begin
        state    <= OVER;
        who      <= WHO_LOSER;
        gameover <= 1'b1;
      end
    end
  end

  assign win = (count == CNT_MAX) && (state != IDLE);
  assign los = (count == '0) && (state != IDLE);

endmodule

// File: tb/tb_game_state_gen2.sv
// Directed table, async-reset sequence and random play checked against an arithmetic game model.
module tb_game_state_gen2;

  localparam int unsigned CS = 4;
  localparam int unsigned SS = 4;
  localparam int unsigned WL = 3;
  localparam int unsigned LL = 2;
  localparam int unsigned SB = 2;
  localparam int MOD  = 1 << CS;
  localparam int CMAX = MOD - 1;
  localparam int SMAX = (1 << SS) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    control = 2'b00;
  logic          init = 1'b0;
  logic [CS-1:0] i_value = '0;
  logic          restart = 1'b0;
  logic [CS-1:0] count;
  logic          win;
  logic          los;
  logic [SS-1:0] wins;
  logic [SS-1:0] losses;
  logic [1:0]    who;
  logic          gameover;

  game_state_gen2 #(
    .COUNTER_SIZE(CS), .SCORE_SIZE(SS), .WIN_LIMIT(WL), .LOSE_LIMIT(LL), .STEP_BIG(SB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .control(control), .init(init),
    .i_value(i_value), .restart(restart), .count(count), .win(win), .los(los),
    .wins(wins), .losses(losses), .who(who), .gameover(gameover)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 play, 2 over; who 0 none, 1 loser, 2 winner
  int m_st = 0, m_cnt = 0, m_wins = 0, m_los = 0, m_who = 0;

  function void model_reset();
    m_st = 0; m_cnt = 0; m_wins = 0; m_los = 0; m_who = 0;
  endfunction

  function void model_step(input logic e, input logic [1:0] c, input logic in,
                           input int iv, input logic rs);
    int d;
    int n;
    if (rs) begin
      model_reset();
    end else if (in && m_st != 2) begin
      m_st = 1; m_cnt = iv; m_wins = 0; m_los = 0; m_who = 0;
    end else if (m_st == 1 && e) begin
      d = c[0] ? int'(SB) : 1;
      if (c[1]) d = -d;
      n = ((m_cnt + d) % MOD + MOD) % MOD;
      if (n != m_cnt && n == CMAX) begin
        if (m_wins < SMAX) m_wins = m_wins + 1;
        if (m_wins == int'(WL)) begin m_st = 2; m_who = 2; end
      end else if (n != m_cnt && n == 0) begin
        if (m_los < SMAX) m_los = m_los + 1;
        if (m_los == int'(LL)) begin m_st = 2; m_who = 1; end
      end
      m_cnt = n;
    end
  endfunction

  function logic [16:0] model_out();
    return {CS'(m_cnt), SS'(m_wins), SS'(m_los), 2'(m_who), (m_st == 2),
            (m_cnt == CMAX && m_st != 0), (m_cnt == 0 && m_st != 0)};
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {count, wins, losses, who, gameover, win, los};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d wins=%0d losses=%0d who=%b go=%b win=%b los=%b, want cnt=%0d wins=%0d losses=%0d who=%b go=%b win=%b los=%b",
               name, act[16:13], act[12:9], act[8:5], act[4:3], act[2], act[1], act[0],
               exp[16:13], exp[12:9], exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Inputs are applied just after an edge, held through the next one, then outputs sampled
  task automatic cyc(input logic e, input logic [1:0] c, input logic in,
                     input logic [CS-1:0] iv, input logic rs);
    en = e; control = c; init = in; i_value = iv; restart = rs;
    @(posedge clk);
    model_step(e, c, in, int'(iv), rs);
    #1;
  endtask

  typedef struct {
    logic e; logic [1:0] c; logic in; logic [3:0] iv; logic rs;
    logic [3:0] cnt; logic [3:0] w; logic [3:0] l; logic [1:0] wh;
    logic go; logic wi; logic lo;
  } vec_t;

  function automatic vec_t mk(input int e, c, in, iv, rs, cnt, w, l, wh, go, wi, lo);
    vec_t v;
    v.e = e[0]; v.c = c[1:0]; v.in = in[0]; v.iv = iv[3:0]; v.rs = rs[0];
    v.cnt = cnt[3:0]; v.w = w[3:0]; v.l = l[3:0]; v.wh = wh[1:0];
    v.go = go[0]; v.wi = wi[0]; v.lo = lo[0];
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    // en ctl init ival rst | count wins losses who gameover win los
    tbl[0]  = mk(0, 0, 1, 14, 0, 14, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 3, 0, 0, 0, 15, 2, 1, 0, 0, 1, 0);
    for (int i = 5; i < 10; i++) tbl[i] = mk(0, 0, 0, 0, 0, 15, 2, 1, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 15, 0, 15, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1);
    tbl[12] = mk(1, 2, 0, 0, 0, 15, 1, 1, 0, 0, 1, 0);
    tbl[13] = mk(1, 2, 0, 0, 0, 14, 1, 1, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 15, 2, 1, 0, 0, 1, 0);
    tbl[15] = mk(1, 2, 0, 0, 0, 14, 2, 1, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 15, 3, 1, 2, 1, 1, 0);
    tbl[17] = mk(1, 2, 0, 0, 0, 15, 3, 1, 2, 1, 1, 0);
    tbl[18] = mk(1, 0, 1, 5, 0, 15, 3, 1, 2, 1, 1, 0);
    tbl[19] = mk(1, 0, 1, 5, 1,  0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(1, 2, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1);
    tbl[23] = mk(1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    tbl[24] = mk(1, 2, 0, 0, 0,  0, 0, 2, 1, 1, 0, 1);
    tbl[25] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

    #12;
    check("reset_state", 17'd0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].e, tbl[i].c, tbl[i].in, tbl[i].iv, tbl[i].rs);
      check($sformatf("table[%0d]", i),
            {tbl[i].cnt, tbl[i].w, tbl[i].l, tbl[i].wh, tbl[i].go, tbl[i].wi, tbl[i].lo});
    end

    // Async reset mid-PLAY: reach count=7 with wins=2, then drop reset_n between edges
    cyc(0, 2'b00, 1, 4'd14, 0);
    cyc(1, 2'b00, 0, 4'd0, 0);
    cyc(1, 2'b10, 0, 4'd0, 0);
    cyc(1, 2'b00, 0, 4'd0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2'b11, 0, 4'd0, 0);
    check("pre_reset", {4'd7, 4'd2, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0});
    en = 1'b0; control = 2'b00;
    #2 reset_n = 1'b0;
    #1 check("async_reset", 17'd0);
    model_reset();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle", model_out());

    // Random play against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(3, 0) != 0, 2'($urandom_range(3, 0)),
          $urandom_range(9, 0) == 0, CS'($urandom_range(CMAX, 0)),
          $urandom_range(39, 0) == 0);
      check($sformatf("random[%0d]", i), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
